// File: rtl/pass_req_gen.sv
// pass_req_gen: conditions a raw pedestrian button into a single-cycle
// pass request for the traffic-light controller. The button is
// synchronized and debounced, and each accepted rising edge becomes a
// one-cycle press. One request is held until the light is green. After
// each issued pass a cooldown window discards further presses. A wrapping
// counter records how many passes have been issued.
module pass_req_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int HOLD_OFF   = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             light_g,
  output logic             pass,
  output logic             req_pending,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt
);

  // One-hot state encoding; each bit is decoded directly to an output.
  localparam logic [3:0] ST_IDLE     = 4'b0001;
  localparam logic [3:0] ST_PENDING  = 4'b0010;
  localparam logic [3:0] ST_ISSUE    = 4'b0100;
  localparam logic [3:0] ST_COOLDOWN = 4'b1000;

  localparam int BIT_PENDING  = 1;
  localparam int BIT_ISSUE    = 2;
  localparam int BIT_COOLDOWN = 3;

  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_OFF - 1);

  logic       s1;
  logic       s2;
  logic       btn_stable;
  logic       btn_stable_d;
  logic [7:0] deb_cnt;
  logic [7:0] cool_cnt;
  logic       press;
  logic [3:0] state;
  logic [3:0] next_state;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed from the stable level for DEB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_stable <= 1'b0;
      deb_cnt    <= 8'd0;
    end else if (s2 == btn_stable) begin
      deb_cnt <= 8'd0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_stable <= s2;
      deb_cnt    <= 8'd0;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_stable_d <= 1'b0;
    end else begin
      btn_stable_d <= btn_stable;
    end
  end

  assign press = btn_stable & ~btn_stable_d;

  // Next-state logic; presses outside IDLE are ignored, so they merge or drop naturally.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (press) next_state = ST_PENDING;
      ST_PENDING:  if (light_g) next_state = ST_ISSUE;
      ST_ISSUE:    next_state = ST_COOLDOWN;
      ST_COOLDOWN: if (cool_cnt == 8'd0) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Cooldown timer: loaded during ISSUE, counts down to zero in COOLDOWN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cool_cnt <= 8'd0;
    end else if (state[BIT_ISSUE]) begin
      cool_cnt <= HOLD_LOAD;
    end else if (state[BIT_COOLDOWN] && (cool_cnt != 8'd0)) begin
      cool_cnt <= cool_cnt - 8'd1;
    end
  end

  // Count issued passes; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt <= '0;
    end else if (state[BIT_ISSUE]) begin
      pass_cnt <= pass_cnt + 1'b1;
    end
  end

  assign pass        = state[BIT_ISSUE];
  assign req_pending = state[BIT_PENDING];
  assign busy        = state[BIT_ISSUE] | state[BIT_COOLDOWN];

endmodule

// File: tb/tb_pass_req_gen.sv
// tb_pass_req_gen: directed bench for pass_req_gen. A cycle-level behavioural
// model tracks debounce and request/cooldown timing, and is compared with
// the DUT after every clock edge. Directed scenarios add hand-computed
// literal expectations for latency, busy length, spacing and counter wrap.
module tb_pass_req_gen;

  localparam int DEB_CYCLES = 4;
  localparam int HOLD_OFF   = 16;
  localparam int CNT_W      = 8;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             btn_raw = 1'b0;
  logic             light_g = 1'b0;
  logic             pass;
  logic             req_pending;
  logic             busy;
  logic [CNT_W-1:0] pass_cnt;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;
  int cyc         = 0;

  pass_req_gen #(
    .DEB_CYCLES(DEB_CYCLES),
    .HOLD_OFF  (HOLD_OFF),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .light_g    (light_g),
    .pass       (pass),
    .req_pending(req_pending),
    .busy       (busy),
    .pass_cnt   (pass_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure distances between events.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: the button is seen two cycles late, a level change is
  // accepted after DEB_CYCLES consecutive differing cycles, and each accepted
  // rising edge arms one request. An armed request waits for green, then the
  // block stays busy for HOLD_OFF+1 cycles, the first of which is the pass.
  bit m_s1, m_s2, m_stable, m_stable_d, m_pend;
  int m_run, m_busy_left, m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 <= 0; m_s2 <= 0; m_stable <= 0; m_stable_d <= 0; m_pend <= 0;
      m_run <= 0; m_busy_left <= 0; m_cnt <= 0;
    end else begin
      if (m_busy_left > 0) begin
        if (m_busy_left == HOLD_OFF + 1) m_cnt <= (m_cnt + 1) % (1 << CNT_W);
        m_busy_left <= m_busy_left - 1;
      end else if (m_pend) begin
        if (light_g === 1'b1) begin
          m_pend      <= 0;
          m_busy_left <= HOLD_OFF + 1;
        end
      end else if (m_stable && !m_stable_d) begin
        m_pend <= 1;
      end
      m_stable_d <= m_stable;
      if (m_s2 != m_stable) begin
        if (m_run + 1 == DEB_CYCLES) begin
          m_stable <= m_s2;
          m_run    <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
      m_s2 <= m_s1;
      m_s1 <= btn_raw;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model shortly after every rising edge.
  always @(posedge clk) begin
    #1;
    if (check_en) begin
      checkOutput("cyc_pass", {31'd0, pass}, {31'd0, (m_busy_left == HOLD_OFF + 1)});
      checkOutput("cyc_req_pending", {31'd0, req_pending}, {31'd0, m_pend});
      checkOutput("cyc_busy", {31'd0, busy}, {31'd0, (m_busy_left > 0)});
      checkOutput("cyc_pass_cnt", {24'd0, pass_cnt}, m_cnt);
    end
  end

  task automatic applyStimulus(input logic b, input logic g);
    @(negedge clk);
    btn_raw = b;
    light_g = g;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for a pass pulse; n is the number of edges waited, or -1 on timeout.
  task automatic waitPass(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (pass === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  // Count pass pulses and pending cycles over the next n cycles.
  task automatic watch(input int n, output int passes, output int pendings);
    passes   = 0;
    pendings = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (pass === 1'b1) passes++;
      if (req_pending === 1'b1) pendings++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst     = 1'b0;
    btn_raw = 1'b0;
    light_g = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
  endtask

  initial begin
    int n, np, npend, bc, t1, t2;
    #2 rst = 1'b0;
    idle(3);
    checkOutput("reset_pass", {31'd0, pass}, 0);
    checkOutput("reset_req_pending", {31'd0, req_pending}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_pass_cnt", {24'd0, pass_cnt}, 0);
    check_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Scenario 1: idle inputs never produce a pass.
    $display("[TB] scenario 1: quiet inputs");
    watch(50, np, npend);
    checkOutput("t1_no_pass", np, 0);
    checkOutput("t1_no_pending", npend, 0);
    checkOutput("t1_pass_cnt", {24'd0, pass_cnt}, 0);
    checkOutput("t1_busy", {31'd0, busy}, 0);

    // Scenario 2: held press with green; pass in cycle 9 counting the rise cycle as 1.
    $display("[TB] scenario 2: latency with green");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    waitPass(20, n);
    checkOutput("t2_latency", n + 1, 9);
    bc = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) bc++;
      else break;
    end
    checkOutput("t2_busy_len", bc, 17);
    checkOutput("t2_pass_cnt", {24'd0, pass_cnt}, 1);
    checkOutput("t2_model_cnt", m_cnt, 1);
    watch(30, np, npend);
    checkOutput("t2_held_single", np, 0);
    applyStimulus(1'b0, 1'b1);
    idle(10);

    // Scenario 3: glitches of 3 and 2 cycles are filtered.
    $display("[TB] scenario 3: glitch rejection");
    applyStimulus(1'b1, 1'b1);
    idle(2);
    applyStimulus(1'b0, 1'b1);
    idle(10);
    applyStimulus(1'b1, 1'b1);
    idle(1);
    applyStimulus(1'b0, 1'b1);
    watch(30, np, npend);
    checkOutput("t3_no_pass", np, 0);
    checkOutput("t3_no_pending", npend, 0);
    checkOutput("t3_pass_cnt", {24'd0, pass_cnt}, 1);

    // Scenario 4: request held while red, extra presses merged.
    $display("[TB] scenario 4: wait for green");
    doReset();
    applyStimulus(1'b1, 1'b0);
    idle(12);
    checkOutput("t4_pending", {31'd0, req_pending}, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0);
      idle(7);
      applyStimulus(1'b1, 1'b0);
      idle(7);
    end
    checkOutput("t4_still_pending", {31'd0, req_pending}, 1);
    checkOutput("t4_no_pass_yet", {24'd0, pass_cnt}, 0);
    applyStimulus(1'b1, 1'b1);
    waitPass(10, n);
    checkOutput("t4_green_latency", n + 1, 2);
    checkOutput("t4_pending_clear", {31'd0, req_pending}, 0);
    watch(40, np, npend);
    checkOutput("t4_single_pass", np, 0);
    checkOutput("t4_pass_cnt", {24'd0, pass_cnt}, 1);

    // Scenario 5: press during cooldown dropped; next pass spaced >= 19 cycles.
    $display("[TB] scenario 5: cooldown drop");
    doReset();
    applyStimulus(1'b1, 1'b1);
    waitPass(20, n);
    checkOutput("t5_first_latency", n + 1, 9);
    t1 = cyc;
    applyStimulus(1'b0, 1'b1);
    idle(6);
    applyStimulus(1'b1, 1'b1);
    watch(20, np, npend);
    checkOutput("t5_dropped", np, 0);
    checkOutput("t5_no_pending", npend, 0);
    checkOutput("t5_idle", {31'd0, busy}, 0);
    applyStimulus(1'b0, 1'b1);
    idle(8);
    applyStimulus(1'b1, 1'b1);
    waitPass(30, n);
    t2 = cyc;
    checkOutput("t5_second_seen", {31'd0, (n > 0)}, 1);
    checkOutput("t5_spacing_ok", {31'd0, ((t2 - t1) >= 19)}, 1);
    checkOutput("t5_pass_cnt_after", {24'd0, pass_cnt}, 1);
    idle(20);
    checkOutput("t5_pass_cnt", {24'd0, pass_cnt}, 2);

    // Scenario 6a: asynchronous reset while pending.
    $display("[TB] scenario 6: reset abort and wrap");
    doReset();
    applyStimulus(1'b1, 1'b0);
    idle(12);
    checkOutput("t6_pending_before", {31'd0, req_pending}, 1);
    #2;
    rst     = 1'b0;
    btn_raw = 1'b0;
    #1;
    checkOutput("t6_async_pending", {31'd0, req_pending}, 0);
    checkOutput("t6_async_pass", {31'd0, pass}, 0);
    idle(3);
    light_g = 1'b1;
    rst     = 1'b1;
    watch(20, np, npend);
    checkOutput("t6_no_pass_after_abort", np, 0);

    // Scenario 6b: asynchronous reset during cooldown.
    applyStimulus(1'b1, 1'b1);
    waitPass(20, n);
    idle(3);
    checkOutput("t6_busy_before", {31'd0, busy}, 1);
    #2;
    rst     = 1'b0;
    btn_raw = 1'b0;
    #1;
    checkOutput("t6_async_busy", {31'd0, busy}, 0);
    checkOutput("t6_async_cnt", {24'd0, pass_cnt}, 0);
    idle(3);
    rst = 1'b1;
    idle(3);

    // Scenario 6c: 256 passes wrap the counter back to zero.
    for (int k = 0; k < 255; k++) begin
      applyStimulus(1'b1, 1'b1);
      idle(11);
      applyStimulus(1'b0, 1'b1);
      idle(11);
    end
    checkOutput("t6_cnt_255", {24'd0, pass_cnt}, 255);
    applyStimulus(1'b1, 1'b1);
    idle(11);
    applyStimulus(1'b0, 1'b1);
    idle(11);
    checkOutput("t6_cnt_wrap", {24'd0, pass_cnt}, 0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
